sf_mavg: RTL and testbench

Parametrised, multi-channel moving-average smoothing filter; next generation of the single-channel `sf` filter. It accepts a time-multiplexed stream of signed samples, each tagged with a channel number. For each sample it emits the mean of the last 2^LOG2_WIN samples of that channel, registered, one cycle later. It sits between the sample source and the downstream logger/DSP chain and replaces `sf` where more than one channel or a different window is needed.

---
 rtl/sf_pkg.sv | 24 ++
 rtl/sf_hist_buf.sv | 36 +++
 rtl/sf_mavg.sv | 102 ++++++++++
 tb/tb_sf_mavg.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sf_pkg.sv
// Shared constants, channel-width helper and per-channel state record for the
// multi-channel moving-average filter.
package sf_pkg;

    localparam int LOG2_WIN_MIN = 1;
    localparam int LOG2_WIN_MAX = 6;
    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 16;
    localparam int DATA_W_MAX   = 32;
    localparam int SUM_W_MAX    = DATA_W_MAX + LOG2_WIN_MAX;

    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Fields are sized for the largest legal configuration; the unused upper
    // bits stay constant and are trimmed away by synthesis.
    typedef struct packed {
        logic signed [SUM_W_MAX-1:0]  sum;
        logic        [LOG2_WIN_MAX-1:0] wp;
        logic        [LOG2_WIN_MAX:0]   fill;
    } ch_state_t;

endpackage

// File: rtl/sf_hist_buf.sv
// Per-channel circular sample history: combinational read of the slot about
// to be overwritten, synchronous write, synchronous clear.
module sf_hist_buf #(
    parameter int DATA_W   = 16,
    parameter int LOG2_WIN = 2,
    parameter int CHANNELS = 1,
    parameter int CH_W     = 1
) (
    input  logic                     clk_i,
    input  logic                     clr_i,
    input  logic                     wr_en_i,
    input  logic [CH_W-1:0]          ch_i,
    input  logic [LOG2_WIN-1:0]      wp_i,
    input  logic signed [DATA_W-1:0] wr_data_i,
    output logic signed [DATA_W-1:0] old_o
);

    localparam int N = 1 << LOG2_WIN;

    logic signed [DATA_W-1:0] mem_q [CHANNELS][N];

    assign old_o = mem_q[ch_i][wp_i];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int w = 0; w < N; w++) begin
                    mem_q[c][w] <= '0;
                end
            end
        end else if (wr_en_i) begin
            mem_q[ch_i][wp_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/sf_mavg.sv
// Multi-channel moving-average filter: per-channel running sum over the last
// 2^LOG2_WIN samples, result registered one cycle after each accepted sample.
module sf_mavg
    import sf_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int LOG2_WIN = 2,
    parameter int CHANNELS = 1,
    parameter int CH_W     = ch_width(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] data_in,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     out_primed
);

    localparam int N = 1 << LOG2_WIN;
    localparam logic [LOG2_WIN_MAX-1:0] WP_MASK = LOG2_WIN_MAX'(N - 1);
    localparam logic [LOG2_WIN_MAX:0]   FILL_N  = (LOG2_WIN_MAX + 1)'(N);

    if (LOG2_WIN < LOG2_WIN_MIN || LOG2_WIN > LOG2_WIN_MAX ||
        CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
        DATA_W > DATA_W_MAX) begin : g_bad_param
        $error("sf_mavg: parameter out of legal range");
    end

    logic                     clr;
    logic                     accept;
    logic [CH_W-1:0]          ch_sel;
    logic signed [DATA_W-1:0] old_data;
    ch_state_t                cur_st;
    ch_state_t                st_d;
    ch_state_t                st_q [CHANNELS];

    logic                     out_valid_q;
    logic [CH_W-1:0]          out_ch_q;
    logic signed [DATA_W-1:0] data_q;
    logic                     primed_q;

    assign clr    = rst | flush;
    assign accept = in_valid && !clr && (int'(in_ch) < CHANNELS);
    // Out-of-range channels never reach the arrays, even for the unused read.
    assign ch_sel = accept ? in_ch : '0;

    sf_hist_buf #(
        .DATA_W   (DATA_W),
        .LOG2_WIN (LOG2_WIN),
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_hist (
        .clk_i     (clk),
        .clr_i     (clr),
        .wr_en_i   (accept),
        .ch_i      (ch_sel),
        .wp_i      (cur_st.wp[LOG2_WIN-1:0]),
        .wr_data_i (data_in),
        .old_o     (old_data)
    );

    always_comb begin
        cur_st   = st_q[ch_sel];
        st_d     = cur_st;
        st_d.sum = cur_st.sum + SUM_W_MAX'(data_in) - SUM_W_MAX'(old_data);
        st_d.wp  = (cur_st.wp + 1'b1) & WP_MASK;
        if (cur_st.fill < FILL_N) begin
            st_d.fill = cur_st.fill + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int c = 0; c < CHANNELS; c++) begin
                st_q[c] <= '0;
            end
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            data_q      <= '0;
            primed_q    <= 1'b0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                st_q[ch_sel] <= st_d;
                out_ch_q     <= in_ch;
                // Bit-select of the two's-complement sum is the floor-divide by N.
                data_q       <= st_d.sum[LOG2_WIN +: DATA_W];
                primed_q     <= (st_d.fill == FILL_N);
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign data_out   = data_q;
    assign out_primed = primed_q;

endmodule

// File: tb/tb_sf_mavg.sv
// Directed and randomized checks of sf_mavg (3 channels, N=4) against a
// queue-based windowed-mean reference model.
module tb_sf_mavg;

    localparam int DATA_W   = 16;
    localparam int LOG2_WIN = 2;
    localparam int N        = 4;
    localparam int CH       = 3;
    localparam int CH_W     = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     in_valid;
    logic [CH_W-1:0]          in_ch;
    logic signed [DATA_W-1:0] data_in;
    logic                     out_valid;
    logic [CH_W-1:0]          out_ch;
    logic signed [DATA_W-1:0] data_out;
    logic                     out_primed;

    int n_checks = 0;
    int n_pass   = 0;

    int hq [CH][$];
    int exp_valid, exp_data, exp_ch, exp_primed;

    always #5 clk = ~clk;

    sf_mavg #(
        .DATA_W   (DATA_W),
        .LOG2_WIN (LOG2_WIN),
        .CHANNELS (CH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ch      (in_ch),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .data_out   (data_out),
        .out_primed (out_primed)
    );

    function automatic int floor_div(input int s);
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input int expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic model_clear();
        for (int c = 0; c < CH; c++) hq[c].delete();
        exp_valid  = 0;
        exp_data   = 0;
        exp_ch     = 0;
        exp_primed = 0;
    endtask

    task automatic model_step(input bit v, input int ch, input int d, input bit fl);
        int s;
        if (fl) begin
            model_clear();
        end else if (v && ch < CH) begin
            hq[ch].push_back(d);
            if (hq[ch].size() > N) void'(hq[ch].pop_front());
            s = 0;
            foreach (hq[ch][i]) s += hq[ch][i];
            exp_valid  = 1;
            exp_data   = floor_div(s);
            exp_ch     = ch;
            exp_primed = (hq[ch].size() == N) ? 1 : 0;
        end else begin
            exp_valid = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"},  out_valid,  exp_valid);
        chk({tag, ".data"},   data_out,   exp_data);
        chk({tag, ".ch"},     out_ch,     exp_ch);
        chk({tag, ".primed"}, out_primed, exp_primed);
    endtask

    task automatic step(input bit v, input int ch, input int d, input bit fl);
        in_valid = v;
        in_ch    = ch[CH_W-1:0];
        data_in  = d[DATA_W-1:0];
        flush    = fl;
        @(posedge clk);
        #1;
        model_step(v, ch, d, fl);
        compare_all("model");
    endtask

    task automatic exp_out(input string tag, input int v, input int d, input int p);
        chk({tag, ".valid"}, out_valid, v);
        if (v != 0) begin
            chk({tag, ".data"},   data_out,   d);
            chk({tag, ".primed"}, out_primed, p);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_ch    = '0;
        data_in  = 16'sd77;
        @(posedge clk);
        #1;
        model_clear();
        compare_all("reset");
        rst = 1'b0;
    endtask

    initial begin
        logic signed [15:0] r;
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_ch    = '0;
        data_in  = 16'sd123;
        @(posedge clk);
        do_reset();

        // Single-channel fill and steady state
        step(1, 0, 100, 0); exp_out("seq1", 1, 25, 0);
        step(1, 0, 200, 0); exp_out("seq2", 1, 75, 0);
        step(1, 0, 150, 0); exp_out("seq3", 1, 112, 0);
        step(1, 0, 250, 0); exp_out("seq4", 1, 175, 1);
        step(1, 0, 180, 0); exp_out("seq5", 1, 195, 1);

        // Floor toward minus infinity
        step(0, 0, 0, 1);   exp_out("flush_a", 0, 0, 0);
        step(1, 0, -1, 0);  exp_out("neg1", 1, -1, 0);
        step(1, 0, 1, 0);   exp_out("neg2", 1, 0, 0);
        step(1, 0, 1, 0);   exp_out("neg3", 1, 0, 0);
        step(1, 0, 1, 0);   exp_out("neg4", 1, 0, 1);

        // Interleaved channels
        step(0, 0, 0, 1);
        step(1, 0, 100, 0);  exp_out("il1", 1, 25, 0);   chk("il1.ch", out_ch, 0);
        step(1, 1, -400, 0); exp_out("il2", 1, -100, 0); chk("il2.ch", out_ch, 1);
        step(1, 0, 300, 0);  exp_out("il3", 1, 100, 0);  chk("il3.ch", out_ch, 0);
        step(1, 1, -400, 0); exp_out("il4", 1, -200, 0); chk("il4.ch", out_ch, 1);

        // Flush wins over a simultaneous sample
        step(0, 0, 0, 1);
        step(1, 0, 10, 0);
        step(1, 0, 20, 0);
        step(1, 0, 30, 0);
        step(1, 0, 500, 1); exp_out("flush_pri", 0, 0, 0);
        step(1, 0, 40, 0);  exp_out("after_flush", 1, 10, 0);

        // Out-of-range channel is dropped
        step(1, 3, 999, 0); exp_out("bad_ch", 0, 0, 0);
        chk("bad_ch.hold", data_out, 10);
        step(1, 0, 80, 0);  exp_out("after_bad", 1, 30, 0);

        // Extremes
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 2, 32767, 0);
        exp_out("max", 1, 32767, 1);
        for (int i = 0; i < 4; i++) step(1, 2, -32768, 0);
        exp_out("min", 1, -32768, 1);

        // Randomized traffic with occasional flush and one reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                do_reset();
            end else begin
                r = 16'($urandom);
                step(($urandom_range(0, 99) < 80), int'($urandom_range(0, 3)),
                     int'(r), ($urandom_range(0, 99) < 2));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
